sram_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared off-chip SRAM path. Accepts word read/write requests from two independent requesters (e.g. image loader and edge-detector writeback), grants them round-robin, and drives the single `sram_iface` start/writemode/address/data handshake. Completion, including read data, is returned to the granted requester only. Sits between the processing datapath and `sram_iface`, one clock domain.

---
 rtl/sram_arbiter_if.sv | 40 ++++
 rtl/sram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Bundles the two requester ports and the sram_iface handshake driven by sram_arbiter.
// slave is the arbiter's view; master is the view of the requesters plus the SRAM side.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              wr0;
  logic              wr1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              err0;
  logic              err1;
  logic              busy;
  logic              if_start;
  logic              if_writemode;
  logic [ADDR_W-1:0] if_address;
  logic [DATA_W-1:0] if_w_data;
  logic [DATA_W-1:0] if_r_data;
  logic              if_done;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, if_r_data, if_done,
    output ack0, ack1, rdata0, rdata1, err0, err1, busy,
           if_start, if_writemode, if_address, if_w_data
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, if_r_data, if_done,
    input  ack0, ack1, rdata0, rdata1, err0, err1, busy,
           if_start, if_writemode, if_address, if_w_data
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of sram_iface; all outputs registered.
// Optional WAIT timeout enabled by defining SRAM_ARB_TIMEOUT_EN.
module sram_arbiter #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              start_q, start_d;
  logic              wm_q, wm_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              busy_q, busy_d;
  logic              sel;
  logic              timeout;

  // Contention goes to the port not served last; a lone requester always wins.
  assign sel = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES) : 8;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err0_q, err0_d;
  logic            err1_q, err1_d;

  assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d  = cnt_q;
    err0_d = 1'b0;
    err1_d = 1'b0;
    if (state_q == StIssue) begin
      cnt_d = '0;
    end else if (state_q == StWait && !bus.if_done) begin
      if (timeout) begin
        err0_d = ~gnt_q;
        err1_d = gnt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      err0_q <= err0_d;
      err1_q <= err1_d;
    end
  end

  assign bus.err0 = err0_q;
  assign bus.err1 = err1_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
  assign bus.err0   = 1'b0;
  assign bus.err1   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    start_d  = 1'b0;
    wm_d     = wm_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          gnt_d   = sel;
          last_d  = sel;
          wm_d    = sel ? bus.wr1 : bus.wr0;
          addr_d  = sel ? bus.addr1 : bus.addr0;
          wdata_d = sel ? bus.wdata1 : bus.wdata0;
          start_d = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (bus.if_done) begin
          state_d = StDone;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          if (!wm_q) begin
            if (gnt_q) rdata1_d = bus.if_r_data;
            else       rdata0_d = bus.if_r_data;
          end
        end else if (timeout) begin
          // Abort: acknowledge with error, read data left untouched.
          state_d = StDone;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      start_q  <= 1'b0;
      wm_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      start_q  <= start_d;
      wm_q     <= wm_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.ack0         = ack0_q;
  assign bus.ack1         = ack1_q;
  assign bus.rdata0       = rdata0_q;
  assign bus.rdata1       = rdata1_q;
  assign bus.busy         = busy_q;
  assign bus.if_start     = start_q;
  assign bus.if_writemode = wm_q;
  assign bus.if_address   = addr_q;
  assign bus.if_w_data    = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter; timeout checks follow SRAM_ARB_TIMEOUT_EN.
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;

  sram_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus_if ();

  sram_arbiter #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic seen_ack;
    rst              = 1'b1;
    bus_if.req0      = 1'b0;
    bus_if.req1      = 1'b0;
    bus_if.wr0       = 1'b0;
    bus_if.wr1       = 1'b0;
    bus_if.addr0     = '0;
    bus_if.addr1     = '0;
    bus_if.wdata0    = '0;
    bus_if.wdata1    = '0;
    bus_if.if_r_data = '0;
    bus_if.if_done   = 1'b0;
    cyc();
    cyc();

    // Reset state
    chk("rst_busy", 64'(bus_if.busy), 64'd0);
    chk("rst_acks", 64'({bus_if.ack0, bus_if.ack1, bus_if.err0, bus_if.err1}), 64'd0);
    chk("rst_start", 64'({bus_if.if_start, bus_if.if_writemode}), 64'd0);
    chk("rst_addr", 64'(bus_if.if_address), 64'd0);
    chk("rst_wdata", 64'(bus_if.if_w_data), 64'd0);
    chk("rst_rdata", {bus_if.rdata0, bus_if.rdata1}, 64'd0);

    // Single write on port 0: cycle 0 now
    rst           = 1'b0;
    bus_if.req0   = 1'b1;
    bus_if.wr0    = 1'b1;
    bus_if.addr0  = 16'h00FA;
    bus_if.wdata0 = 32'hAB;
    cyc();  // cycle 1
    chk("wr_start", 64'(bus_if.if_start), 64'd1);
    chk("wr_addr", 64'(bus_if.if_address), 64'h00FA);
    chk("wr_wdata", 64'(bus_if.if_w_data), 64'hAB);
    chk("wr_mode", 64'(bus_if.if_writemode), 64'd1);
    chk("wr_busy", 64'(bus_if.busy), 64'd1);
    cyc();  // cycle 2
    chk("wr_start_pulse", 64'(bus_if.if_start), 64'd0);
    cyc();  // cycle 3
    bus_if.if_done = 1'b1;
    chk("wr_no_early_ack", 64'(bus_if.ack0), 64'd0);
    cyc();  // cycle 4
    bus_if.if_done = 1'b0;
    bus_if.req0    = 1'b0;
    chk("wr_ack0", 64'(bus_if.ack0), 64'd1);
    chk("wr_ack1", 64'(bus_if.ack1), 64'd0);
    chk("wr_err0", 64'(bus_if.err0), 64'd0);
    chk("wr_rdata0", 64'(bus_if.rdata0), 64'd0);
    cyc();  // cycle 5, idle
    chk("wr_ack_pulse", 64'(bus_if.ack0), 64'd0);
    chk("wr_idle", 64'(bus_if.busy), 64'd0);

    // Single read on port 1
    bus_if.req1      = 1'b1;
    bus_if.wr1       = 1'b0;
    bus_if.addr1     = 16'h0001;
    bus_if.if_r_data = 32'hCD;
    cyc();
    chk("rd_addr", 64'(bus_if.if_address), 64'h0001);
    chk("rd_mode", 64'(bus_if.if_writemode), 64'd0);
    cyc();
    bus_if.if_done = 1'b1;
    cyc();
    bus_if.if_done = 1'b0;
    bus_if.req1    = 1'b0;
    chk("rd_ack1", 64'(bus_if.ack1), 64'd1);
    chk("rd_ack0", 64'(bus_if.ack0), 64'd0);
    chk("rd_rdata1", 64'(bus_if.rdata1), 64'hCD);
    chk("rd_rdata0", 64'(bus_if.rdata0), 64'd0);
    cyc();
    chk("rd_hold", 64'(bus_if.rdata1), 64'hCD);

    // Contention from reset, both held for 4 transactions
    rst          = 1'b1;
    bus_if.req0  = 1'b1;
    bus_if.req1  = 1'b1;
    bus_if.wr0   = 1'b1;
    bus_if.wr1   = 1'b1;
    bus_if.addr0 = 16'h0010;
    bus_if.addr1 = 16'h0020;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("rr_addr%0d", k), 64'(bus_if.if_address), (k % 2 == 0) ? 64'h10 : 64'h20);
      cyc();
      bus_if.if_done = 1'b1;
      cyc();
      bus_if.if_done = 1'b0;
      chk($sformatf("rr_ack%0d", k), 64'({bus_if.ack1, bus_if.ack0}),
          (k % 2 == 0) ? 64'b01 : 64'b10);
      cyc();
    end
    bus_if.req0 = 1'b0;
    bus_if.req1 = 1'b0;
    cyc();

    // Stability of latched fields, then spurious if_done in idle
    bus_if.req0  = 1'b1;
    bus_if.wr0   = 1'b0;
    bus_if.addr0 = 16'h0055;
    cyc();
    cyc();
    bus_if.addr0 = 16'h0099;
    bus_if.wr0   = 1'b1;
    cyc();
    chk("stab_addr_wait", 64'(bus_if.if_address), 64'h0055);
    bus_if.if_r_data = 32'h77;
    bus_if.if_done   = 1'b1;
    cyc();
    bus_if.if_done = 1'b0;
    bus_if.req0    = 1'b0;
    chk("stab_ack0", 64'(bus_if.ack0), 64'd1);
    chk("stab_addr_done", 64'(bus_if.if_address), 64'h0055);
    chk("stab_rdata0", 64'(bus_if.rdata0), 64'h77);
    cyc();
    bus_if.if_done = 1'b1;
    cyc();
    cyc();
    bus_if.if_done = 1'b0;
    chk("spur_acks", 64'({bus_if.ack0, bus_if.ack1}), 64'd0);
    chk("spur_busy", 64'(bus_if.busy), 64'd0);

    // Reset mid-WAIT after serving port 0, then contention must go to port 0
    bus_if.req0  = 1'b1;
    bus_if.wr0   = 1'b1;
    bus_if.addr0 = 16'h0033;
    cyc();
    cyc();
    cyc();
    rst         = 1'b1;
    bus_if.req0 = 1'b0;
    cyc();
    rst = 1'b0;
    chk("mrst_busy", 64'(bus_if.busy), 64'd0);
    chk("mrst_acks", 64'({bus_if.ack0, bus_if.ack1, bus_if.if_start}), 64'd0);
    chk("mrst_addr", 64'(bus_if.if_address), 64'd0);
    chk("mrst_rdata", {bus_if.rdata0, bus_if.rdata1}, 64'd0);
    bus_if.req0  = 1'b1;
    bus_if.req1  = 1'b1;
    bus_if.addr0 = 16'h0044;
    bus_if.addr1 = 16'h0066;
    cyc();
    chk("mrst_grant", 64'(bus_if.if_address), 64'h0044);
    cyc();
    bus_if.if_done = 1'b1;
    cyc();
    bus_if.if_done = 1'b0;
    bus_if.req0    = 1'b0;
    bus_if.req1    = 1'b0;
    chk("mrst_ack0", 64'({bus_if.ack1, bus_if.ack0}), 64'b01);
    cyc();

    // Withheld if_done
    bus_if.req0      = 1'b1;
    bus_if.wr0       = 1'b0;
    bus_if.addr0     = 16'h0077;
    bus_if.if_r_data = 32'hEE;
    cyc();  // cycle 1
    cyc();  // cycle 2, first WAIT cycle
`ifdef SRAM_ARB_TIMEOUT_EN
    seen_ack = 1'b0;
    for (int i = 0; i < 63; i++) begin
      cyc();
      seen_ack = seen_ack | bus_if.ack0;
    end
    chk("to_no_early_ack", 64'(seen_ack), 64'd0);
    chk("to_busy", 64'(bus_if.busy), 64'd1);
    cyc();  // cycle 66
    bus_if.req0 = 1'b0;
    chk("to_ack0", 64'(bus_if.ack0), 64'd1);
    chk("to_err0", 64'(bus_if.err0), 64'd1);
    chk("to_err1", 64'(bus_if.err1), 64'd0);
    chk("to_rdata0", 64'(bus_if.rdata0), 64'd0);
    cyc();
    chk("to_idle", 64'({bus_if.busy, bus_if.ack0, bus_if.err0}), 64'd0);
`else
    seen_ack = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      seen_ack = seen_ack | bus_if.ack0 | bus_if.err0;
    end
    chk("hold_no_ack", 64'(seen_ack), 64'd0);
    chk("hold_busy", 64'(bus_if.busy), 64'd1);
    rst         = 1'b1;
    bus_if.req0 = 1'b0;
    cyc();
    rst = 1'b0;
    chk("hold_rst_busy", 64'(bus_if.busy), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
